// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin ALU/LSU with low-priority debug,
// a single write-stage register, and an issue scoreboard of pending writes.
module regfile_wb_arbiter #(
  parameter int CNT_W  = 16,
  parameter bit DBG_EN = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_issue_valid,
  input  logic [31:0]      i_IR,
  output logic             o_stall,
  input  logic             i_alu_valid,
  output logic             o_alu_ready,
  input  logic [4:0]       i_alu_rd,
  input  logic [31:0]      i_alu_data,
  input  logic             i_lsu_valid,
  output logic             o_lsu_ready,
  input  logic [4:0]       i_lsu_rd,
  input  logic [31:0]      i_lsu_data,
  input  logic             i_dbg_valid,
  output logic             o_dbg_ready,
  input  logic [4:0]       i_dbg_rd,
  input  logic [31:0]      i_dbg_data,
  output logic             o_wr_en,
  output logic [4:0]       o_wr_addr,
  output logic [31:0]      o_wr_data,
  output logic [31:0]      o_busy,
  output logic [CNT_W-1:0] o_wr_count
);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_e;

  src_e              rr_last;
  logic [31:0]       busy_q;
  logic [4:0]        rs1, rs2, rd;
  logic              ir_unused;
  logic              issue_go;
  logic              acc_alu, acc_lsu, acc_dbg, acc_any;
  logic [4:0]        sel_rd;
  logic [31:0]       sel_data;
  logic              sel_dbg;
  logic [31:0]       set_mask, clr_mask;
  logic              vld_p0;
  logic              dbg_p0;
  logic [4:0]        addr_p0;
  logic [31:0]       data_p0;
  logic [CNT_W-1:0]  cnt_q;

  assign rd  = i_IR[11:7];
  assign rs1 = i_IR[19:15];
  assign rs2 = i_IR[24:20];
  assign ir_unused = ^{i_IR[31:25], i_IR[14:12], i_IR[6:0]};

  // busy_q[0] is held at zero, so x0 operands never stall
  assign o_stall  = i_issue_valid && (busy_q[rs1] || busy_q[rs2] || busy_q[rd]);
  assign issue_go = i_issue_valid && !o_stall;

  assign o_alu_ready = i_alu_valid && (!i_lsu_valid || (rr_last == SRC_LSU));
  assign o_lsu_ready = i_lsu_valid && (!i_alu_valid || (rr_last == SRC_ALU));
  assign o_dbg_ready = DBG_EN && i_dbg_valid && !i_alu_valid && !i_lsu_valid;

  assign acc_alu = i_alu_valid && o_alu_ready;
  assign acc_lsu = i_lsu_valid && o_lsu_ready;
  assign acc_dbg = i_dbg_valid && o_dbg_ready;
  assign acc_any = acc_alu || acc_lsu || acc_dbg;

  always_comb begin
    sel_rd   = i_dbg_rd;
    sel_data = i_dbg_data;
    sel_dbg  = 1'b1;
    if (acc_alu) begin
      sel_rd   = i_alu_rd;
      sel_data = i_alu_data;
      sel_dbg  = 1'b0;
    end else if (acc_lsu) begin
      sel_rd   = i_lsu_rd;
      sel_data = i_lsu_data;
      sel_dbg  = 1'b0;
    end
  end

  // Stage p0: write-stage register feeding the register file
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p0  <= 1'b0;
      dbg_p0  <= 1'b0;
      addr_p0 <= '0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= acc_any && (sel_rd != 5'd0);
      if (acc_any) begin
        dbg_p0  <= sel_dbg;
        addr_p0 <= sel_rd;
        data_p0 <= sel_data;
      end
    end
  end

  assign o_wr_en   = vld_p0;
  assign o_wr_addr = addr_p0;
  assign o_wr_data = data_p0;

  // Debug writes bypass the scoreboard; a same-edge issue overrides the clear
  assign set_mask = (issue_go && (rd != 5'd0)) ? (32'd1 << rd) : 32'd0;
  assign clr_mask = (vld_p0 && !dbg_p0) ? (32'd1 << addr_p0) : 32'd0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q  <= '0;
      rr_last <= SRC_LSU;
      cnt_q   <= '0;
    end else begin
      busy_q <= ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
      if (acc_alu) rr_last <= SRC_ALU;
      else if (acc_lsu) rr_last <= SRC_LSU;
      if (vld_p0) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_busy     = busy_q;
  assign o_wr_count = cnt_q;

endmodule
